// File: rtl/bit_population_generator.sv
// Serial frame generator: emits a WIDTH-bit frame, LSB first, whose low N bits are ones.
// Requests above WIDTH saturate to WIDTH and raise a one-cycle err_o pulse.
module bit_population_generator #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  output logic             ready_o,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             ser_last_o,
  output logic             err_o,
  output logic             dbg_state_o
);

  // Handshake: a request is taken on any cycle with data_val_i && ready_o; ready_o
  // depends only on reset, state and bit counter, never on data_val_i or data_i.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic             r_ser_data;
  logic             r_ser_val;
  logic             r_ser_last;
  logic             r_err;

  logic             w_accept;
  logic             w_sat;
  logic [CNT_W-1:0] w_n_eff;
  logic [CNT_W-1:0] w_cnt_inc;

  assign ready_o   = !srst_i && ((r_state == IDLE) || (r_cnt == LAST_C));
  assign w_accept  = data_val_i && ready_o;
  assign w_sat     = data_i > WIDTH_C;
  assign w_n_eff   = w_sat ? WIDTH_C : data_i;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (srst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_ser_last <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_sat;
      if (w_accept) begin
        // Start (or restart back-to-back): bit 0 goes out on the next cycle.
        r_state    <= SHIFT;
        r_cnt      <= '0;
        r_n        <= w_n_eff;
        r_ser_data <= (w_n_eff != '0);
        r_ser_val  <= 1'b1;
        r_ser_last <= 1'b0;
      end else if ((r_state == SHIFT) && (r_cnt != LAST_C)) begin
        r_cnt      <= w_cnt_inc;
        r_ser_data <= (w_cnt_inc < r_n);
        r_ser_val  <= 1'b1;
        r_ser_last <= (w_cnt_inc == LAST_C);
      end else begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_ser_data <= 1'b0;
        r_ser_val  <= 1'b0;
        r_ser_last <= 1'b0;
      end
    end
  end

  assign ser_data_o     = r_ser_data;
  assign ser_data_val_o = r_ser_val;
  assign ser_last_o     = r_ser_last;
  assign err_o          = r_err;
  assign dbg_state_o    = r_state;

endmodule
